// File: rtl/serial_frame_decoder.sv
// serial_frame_decoder
// Recovers data bits from a continuous stream of 3-slot frames
// (start '1', data 'd', stop '0'), acquires frame lock, assembles
// LSB-first words and presents them on a valid/ready output register.
// Optional feature macro: SERIAL_FRAME_DECODER_ERR_CNT_EN enables the
// saturating framing-error counter; otherwise err_count is tied to 0.
//
// state  | meaning
// S_HUNT | waiting for a start slot ('1')
// S_DATA | current slot is the data bit
// S_STOP | current slot must be '0'; '1' is a framing error

module serial_frame_decoder #(
   parameter int WORD_W      = 8,
   parameter int LOCK_FRAMES = 2
) (
   input  logic              CLK,
   input  logic              CLR_N,
   input  logic              din,
   output logic [WORD_W-1:0] data_out,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              locked,
   output logic              frame_err,
   output logic              overflow,
   output logic [7:0]        err_count
);

   localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   typedef enum logic [1:0] {S_HUNT, S_DATA, S_STOP} state_t;

   state_t            state_q, state_d;
   logic              d_bit_q, d_bit_d;
   logic [2:0]        good_cnt_q, good_cnt_d;
   logic              locked_q, locked_d;
   logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [WORD_W-1:0] shreg_q, shreg_d;
   logic [WORD_W-1:0] data_out_q, data_out_d;
   logic              out_valid_q, out_valid_d;
   logic              frame_err_q, frame_err_d;
   logic              overflow_q, overflow_d;
   logic              word_done;
   logic [WORD_W-1:0] new_word;

   // Next-state: frame FSM, lock acquisition, word assembly, output handshake
   always_comb begin
      state_d     = state_q;
      d_bit_d     = d_bit_q;
      good_cnt_d  = good_cnt_q;
      locked_d    = locked_q;
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      data_out_d  = data_out_q;
      out_valid_d = out_valid_q;
      frame_err_d = 1'b0;
      overflow_d  = overflow_q;
      word_done   = 1'b0;
      new_word    = shreg_q | (WORD_W'(d_bit_q) << bit_cnt_q);

      case (state_q)
         S_HUNT: begin
            if (din) state_d = S_DATA;
         end
         S_DATA: begin
            d_bit_d = din;
            state_d = S_STOP;
         end
         S_STOP: begin
            state_d = S_HUNT;
            if (din) begin
               frame_err_d = 1'b1;
               locked_d    = 1'b0;
               good_cnt_d  = '0;
               bit_cnt_d   = '0;
               shreg_d     = '0;
            end else if (!locked_q) begin
               // lock-acquisition frames carry data that is discarded
               if (good_cnt_q + 3'd1 >= 3'(LOCK_FRAMES)) begin
                  good_cnt_d = 3'(LOCK_FRAMES);
                  locked_d   = 1'b1;
               end else begin
                  good_cnt_d = good_cnt_q + 3'd1;
               end
            end else if (bit_cnt_q == BW'(WORD_W - 1)) begin
               word_done = 1'b1;
               bit_cnt_d = '0;
               shreg_d   = '0;
            end else begin
               shreg_d   = new_word;
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         default: state_d = S_HUNT;
      endcase

      // a pending word is consumed on the same edge a new one may load
      if (word_done) begin
         if (!out_valid_q || out_ready) begin
            data_out_d  = new_word;
            out_valid_d = 1'b1;
         end else begin
            overflow_d = 1'b1;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // State and datapath registers with synchronous active-low clear
   always_ff @(posedge CLK) begin
      if (!CLR_N) begin
         state_q     <= S_HUNT;
         d_bit_q     <= 1'b0;
         good_cnt_q  <= '0;
         locked_q    <= 1'b0;
         bit_cnt_q   <= '0;
         shreg_q     <= '0;
         data_out_q  <= '0;
         out_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         d_bit_q     <= d_bit_d;
         good_cnt_q  <= good_cnt_d;
         locked_q    <= locked_d;
         bit_cnt_q   <= bit_cnt_d;
         shreg_q     <= shreg_d;
         data_out_q  <= data_out_d;
         out_valid_q <= out_valid_d;
         frame_err_q <= frame_err_d;
         overflow_q  <= overflow_d;
      end
   end

`ifdef SERIAL_FRAME_DECODER_ERR_CNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   // Saturating count of framing errors, updated with the frame_err pulse
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (frame_err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
   end

   // Error counter register
   always_ff @(posedge CLK) begin
      if (!CLR_N) err_cnt_q <= '0;
      else        err_cnt_q <= err_cnt_d;
   end

   assign err_count = err_cnt_q;
`else
   assign err_count = '0;
`endif

   assign data_out  = data_out_q;
   assign out_valid = out_valid_q;
   assign locked    = locked_q;
   assign frame_err = frame_err_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_frame_decoder.sv
// Directed bench for serial_frame_decoder (WORD_W=8, LOCK_FRAMES=2).
module tb_serial_frame_decoder;

   logic       CLK = 1'b0;
   logic       CLR_N = 1'b0;
   logic       din = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] data_out;
   logic       out_valid;
   logic       locked;
   logic       frame_err;
   logic       overflow;
   logic [7:0] err_count;

   int pass_cnt = 0;
   int total_cnt = 0;

`ifdef SERIAL_FRAME_DECODER_ERR_CNT_EN
   localparam logic [7:0] ERR1 = 8'd1;
`else
   localparam logic [7:0] ERR1 = 8'd0;
`endif

   serial_frame_decoder #(.WORD_W(8), .LOCK_FRAMES(2)) dut (
      .CLK       (CLK),
      .CLR_N     (CLR_N),
      .din       (din),
      .data_out  (data_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .locked    (locked),
      .frame_err (frame_err),
      .overflow  (overflow),
      .err_count (err_count)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "time limit reached");
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic slot(input logic b);
      din = b;
      @(posedge CLK);
      #1;
   endtask

   task automatic frame(input logic b);
      slot(1'b1);
      slot(b);
      slot(1'b0);
   endtask

   task automatic word(input logic [7:0] w);
      for (int i = 0; i < 8; i++) frame(w[i]);
   endtask

   task automatic do_reset();
      CLR_N = 1'b0;
      din   = 1'b0;
      @(posedge CLK);
      #1;
      CLR_N = 1'b1;
   endtask

   initial begin
      // reset state
      out_ready = 1'b1;
      do_reset();
      check("rst_data_out", 16'(data_out), 16'h00);
      check("rst_out_valid", 16'(out_valid), 16'h0);
      check("rst_locked", 16'(locked), 16'h0);
      check("rst_frame_err", 16'(frame_err), 16'h0);
      check("rst_overflow", 16'(overflow), 16'h0);
      check("rst_err_count", 16'(err_count), 16'h0);

      // lock then decode 0xA5 with a single out_valid pulse
      frame(1'b0);
      check("t1_unlocked_after_1", 16'(locked), 16'h0);
      frame(1'b0);
      check("t1_locked_after_2", 16'(locked), 16'h1);
      word(8'hA5);
      check("t1_valid", 16'(out_valid), 16'h1);
      check("t1_data", 16'(data_out), 16'hA5);
      slot(1'b1);
      check("t1_valid_pulse_end", 16'(out_valid), 16'h0);
      check("t1_data_held", 16'(data_out), 16'hA5);

      // stream joined mid-frame: leading d=0, stop=0 slots
      do_reset();
      slot(1'b0);
      check("t2_no_ferr_a", 16'(frame_err), 16'h0);
      slot(1'b0);
      check("t2_no_ferr_b", 16'(frame_err), 16'h0);
      frame(1'b1);
      frame(1'b0);
      check("t2_locked", 16'(locked), 16'h1);
      word(8'h3C);
      check("t2_valid", 16'(out_valid), 16'h1);
      check("t2_data", 16'(data_out), 16'h3C);

      // framing error in the 3rd data frame, then relock and clean word
      do_reset();
      frame(1'b0);
      frame(1'b0);
      frame(1'b1);
      frame(1'b1);
      slot(1'b1);
      slot(1'b0);
      slot(1'b1);
      check("t3_ferr", 16'(frame_err), 16'h1);
      check("t3_unlocked", 16'(locked), 16'h0);
      check("t3_err_count", 16'(err_count), 16'(ERR1));
      slot(1'b0);
      check("t3_ferr_one_cycle", 16'(frame_err), 16'h0);
      check("t3_err_count_hold", 16'(err_count), 16'(ERR1));
      frame(1'b0);
      check("t3_unlocked_1", 16'(locked), 16'h0);
      frame(1'b0);
      check("t3_relocked", 16'(locked), 16'h1);
      word(8'h81);
      check("t3_valid", 16'(out_valid), 16'h1);
      check("t3_data_from_bit0", 16'(data_out), 16'h81);

      // overflow: two words with no consumer
      do_reset();
      out_ready = 1'b0;
      frame(1'b0);
      frame(1'b0);
      word(8'h11);
      check("t4_valid_first", 16'(out_valid), 16'h1);
      check("t4_data_first", 16'(data_out), 16'h11);
      check("t4_no_ovf_yet", 16'(overflow), 16'h0);
      word(8'h22);
      check("t4_data_kept", 16'(data_out), 16'h11);
      check("t4_overflow", 16'(overflow), 16'h1);
      check("t4_valid_still", 16'(out_valid), 16'h1);
      out_ready = 1'b1;
      slot(1'b1);
      check("t4_consumed", 16'(out_valid), 16'h0);
      check("t4_data_after", 16'(data_out), 16'h11);
      check("t4_ovf_sticky", 16'(overflow), 16'h1);

      // ready on the same edge a new word completes
      do_reset();
      out_ready = 1'b0;
      frame(1'b0);
      frame(1'b0);
      word(8'h11);
      check("t5_pending", 16'(data_out), 16'h11);
      for (int i = 0; i < 7; i++) frame(1'((8'h55 >> i) & 8'h01));
      slot(1'b1);
      slot(1'b0);
      check("t5_still_pending", 16'(data_out), 16'h11);
      out_ready = 1'b1;
      slot(1'b0);
      check("t5_valid", 16'(out_valid), 16'h1);
      check("t5_data", 16'(data_out), 16'h55);
      check("t5_no_ovf", 16'(overflow), 16'h0);

      // reset in the middle of a word while locked with a pending word
      do_reset();
      out_ready = 1'b0;
      frame(1'b0);
      frame(1'b0);
      word(8'hF0);
      frame(1'b1);
      frame(1'b1);
      frame(1'b1);
      slot(1'b1);
      check("t6_pre_valid", 16'(out_valid), 16'h1);
      check("t6_pre_locked", 16'(locked), 16'h1);
      CLR_N = 1'b0;
      slot(1'b1);
      CLR_N = 1'b1;
      check("t6_rst_data", 16'(data_out), 16'h00);
      check("t6_rst_valid", 16'(out_valid), 16'h0);
      check("t6_rst_locked", 16'(locked), 16'h0);
      out_ready = 1'b1;
      frame(1'b0);
      check("t6_unlocked_1", 16'(locked), 16'h0);
      frame(1'b0);
      check("t6_relocked", 16'(locked), 16'h1);
      word(8'h96);
      check("t6_valid", 16'(out_valid), 16'h1);
      check("t6_data", 16'(data_out), 16'h96);
      check("t6_no_ovf", 16'(overflow), 16'h0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/serial_frame_decoder.md
# serial_frame_decoder

- Receive-side counterpart of the team's three-slot serial frame generator.
- Input is one line bit per clock, carrying a continuous stream of 3-slot frames: start slot `1`, data slot `d`, stop slot `0`.
- The block finds frame alignment, declares lock after consecutive good frames, and assembles the recovered data bits LSB-first into words.
- Each word is presented on a valid/ready output register, with framing-error and overflow reporting.

## Interface
- `WORD_W`, default 8: recovered bits per output word (2..16).
- `LOCK_FRAMES`, default 2: consecutive good frames required before `locked` rises (1..7).
- `CLK`  in  1  clock; all logic on rising edge.
- `CLR_N`  in  1  reset, synchronous, active-low; sampled on rising `CLK`.
- `din`  in  1  serial line, one slot per clock.
- `data_out`  out  WORD_W  assembled word; bit 0 = first recovered bit.
- `out_valid`  out  1  `data_out` holds an unconsumed word.
- `out_ready`  in  1  consumer accepts the word when `out_valid & out_ready` at a rising edge.
- `locked`  out  1  frame alignment established.
- `frame_err`  out  1  one-cycle pulse: stop slot sampled as `1`.
- `overflow`  out  1  sticky: a completed word was dropped.
- `err_count`  out  8  saturating framing-error count (see Configuration).

## Operation
- FSM states and transitions:
  - HUNT: `din=1` → DATA; `din=0` → stay.
  - DATA: capture `din` as `d` → STOP.
  - STOP: `din=0` is a good frame → HUNT. `din=1` is a framing error → HUNT.
  - Because the stream has no idle slots, in practice the cycle after a good stop is a start slot and HUNT leaves immediately.
- Misalignment by 1 slot fails at the stop slot; misalignment by 2 fails the start check. No extra alignment logic is needed.
- Good-frame counter, 3 bits, saturates at `LOCK_FRAMES`:
  - increments on each good frame while unlocked;
  - `locked` sets on the edge where the count reaches `LOCK_FRAMES`.
  - Data bits of the lock-acquisition frames are discarded.
- While locked, each good frame shifts `d` into the assembly register at bit index = bit counter, then increments the bit counter.
- On the `WORD_W`-th bit:
  - `out_valid=0`: load `data_out`, set `out_valid`.
  - `out_valid=1 & out_ready=1` on the same edge: load the new word and keep `out_valid=1` (the old word is consumed).
  - `out_valid=1 & out_ready=0`: drop the new word, set `overflow`; `data_out` is unchanged.
  - In all cases the bit counter returns to 0.
- `out_valid=1` with no word completing, `out_ready=1`: clear `out_valid`. `data_out` holds its last value.
- Framing error:
  - pulse `frame_err`;
  - clear `locked`, the good-frame counter, the bit counter and the partial word;
  - a pending `out_valid` word is kept.
- `CLR_N=0` at an edge: state returns to HUNT and all counters and registers clear. This also applies mid-frame or mid-word; no partial word survives.

## Timing
- Reset values: `data_out=0`, `out_valid=0`, `locked=0`, `frame_err=0`, `overflow=0`, `err_count=0`, FSM=HUNT.
- `din` is sampled at each rising edge.
- Latency: `out_valid` rises the cycle after the edge that samples the last word's stop slot.
- `frame_err` is high for exactly the cycle after the bad stop slot is sampled.
- `locked` rises the cycle after the `LOCK_FRAMES`-th good stop slot is sampled.
- One word per `3*WORD_W` clocks. A consumer with `out_ready` permanently high never causes overflow.
- `out_ready` is ignored while `out_valid=0`.
- `overflow` clears only on reset.

## Configuration
- `SERIAL_FRAME_DECODER_ERR_CNT_EN` defined: `err_count` increments on every `frame_err` pulse, locked or not, saturating at 255.
- Not defined: no counter logic; `err_count` is tied to 0. The port remains for a uniform interface.

## Test plan
- Reset, then a stream of well-formed frames with d = 0,0 (lock), then 1,0,1,0,0,1,0,1, `out_ready=1`:
  - `locked=1` after frame 2;
  - `data_out=0xA5` with a single `out_valid` pulse exactly 1 cycle after the 10th stop slot.
- Stream starting mid-frame (slots `d`,`0`, then aligned frames):
  - no `frame_err` for the leading `0` slots;
  - lock after 2 full frames;
  - word 0x3C decoded correctly.
- Locked; stop slot of the 3rd data frame forced to `1`:
  - `frame_err` pulses for 1 cycle, `locked=0`, `err_count=1` (macro defined) or 0 (undefined);
  - after relock, the next word decodes from bit 0.
- `out_ready=0`, two words 0x11 then 0x22 sent:
  - `data_out` stays 0x11, `overflow=1`;
  - asserting `out_ready` consumes 0x11, then `out_valid=0`.
- `out_ready` asserted on the same edge a new word 0x55 completes while 0x11 is pending:
  - `out_valid` stays 1, `data_out=0x55`, no overflow.
- `CLR_N=0` for 1 cycle in the middle of a word while locked:
  - all outputs 0 next cycle;
  - 2 good frames are needed to relock.
